// File: rtl/s_axis_rx_buffer.sv
// Two-entry AXI-Stream skid buffer (output register + skid register) with registered ready/valid.
// Optional packet statistics (pkt_count, last_len) compiled in with `define S_AXIS_RX_STATS_EN.
module s_axis_rx_buffer #(
    parameter int C_AXIS_DATA_WIDTH = 128
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [15:0]                  pkt_count,
    output logic [15:0]                  last_len,
    output logic [1:0]                   o_dbg_state
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // once valid is raised, it and its payload hold until ready is seen with it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                         r_state;
    logic                           r_s_ready;
    logic                           r_m_valid;
    logic                           r_out_last;
    logic [C_AXIS_DATA_WIDTH-1:0]   r_out_data;
    logic                           r_skid_last;
    logic [C_AXIS_DATA_WIDTH-1:0]   r_skid_data;

    logic w_accept;
    logic w_deliver;

    assign w_accept  = s_axis_tvalid & r_s_ready;
    assign w_deliver = r_m_valid & m_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_EMPTY;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_skid_last <= 1'b0;
            r_skid_data <= '0;
        end else begin
            // Ready is recomputed every edge from the next state, so it never sees m_axis_tready combinationally.
            r_s_ready <= 1'b1;
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_data <= s_axis_tdata;
                        r_out_last <= s_axis_tlast;
                        r_m_valid  <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({w_accept, w_deliver})
                        2'b11: begin
                            r_out_data <= s_axis_tdata;
                            r_out_last <= s_axis_tlast;
                        end
                        2'b10: begin
                            r_skid_data <= s_axis_tdata;
                            r_skid_last <= s_axis_tlast;
                            r_s_ready   <= 1'b0;
                            r_state     <= ST_FULL;
                        end
                        2'b01: begin
                            r_m_valid <= 1'b0;
                            r_state   <= ST_EMPTY;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    r_s_ready <= w_deliver;
                    if (w_deliver) begin
                        r_out_data <= r_skid_data;
                        r_out_last <= r_skid_last;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tdata  = r_out_data;
    assign o_dbg_state   = r_state;

`ifdef S_AXIS_RX_STATS_EN
    logic [15:0] r_cur_len;
    logic [15:0] r_pkt_count;
    logic [15:0] r_last_len;
    logic [15:0] w_len_inc;

    // Length saturates rather than wrapping so oversized packets read as 0xFFFF.
    assign w_len_inc = (r_cur_len == 16'hFFFF) ? 16'hFFFF : r_cur_len + 16'd1;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cur_len   <= 16'd0;
            r_pkt_count <= 16'd0;
            r_last_len  <= 16'd0;
        end else if (w_deliver) begin
            if (r_out_last) begin
                r_last_len  <= w_len_inc;
                r_cur_len   <= 16'd0;
                r_pkt_count <= r_pkt_count + 16'd1;
            end else begin
                r_cur_len <= w_len_inc;
            end
        end
    end

    assign pkt_count = r_pkt_count;
    assign last_len  = r_last_len;
`else
    assign pkt_count = 16'd0;
    assign last_len  = 16'd0;
`endif

endmodule

// File: doc/s_axis_rx_buffer.md
S_AXIS_RX_BUFFER -- requirements
Module: s_axis_rx_buffer

Interface
REQ-001 The block SHALL have parameter C_AXIS_DATA_WIDTH, default 128, giving the tdata width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port aclk, input, 1 bit: the clock; all logic on the rising edge.
REQ-004 Port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port s_axis_tvalid, input, 1 bit: upstream beat valid.
REQ-006 Port s_axis_tready, output, 1 bit: upstream ready, driven directly from a register.
REQ-007 Port s_axis_tlast, input, 1 bit: upstream end of packet.
REQ-008 Port s_axis_tdata, input, C_AXIS_DATA_WIDTH bits: upstream payload.
REQ-009 Port m_axis_tvalid, output, 1 bit: downstream beat valid, driven directly from a register.
REQ-010 Port m_axis_tready, input, 1 bit: downstream ready.
REQ-011 Port m_axis_tlast, output, 1 bit: downstream end of packet, driven directly from a register.
REQ-012 Port m_axis_tdata, output, C_AXIS_DATA_WIDTH bits: downstream payload, driven directly from a register.
REQ-013 Port pkt_count, output, 16 bits: number of completed packets delivered downstream.
REQ-014 Port last_len, output, 16 bits: beat count of the most recently completed packet.

Function
REQ-015 An upstream beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high at a rising edge; a downstream beat SHALL be delivered when m_axis_tvalid and m_axis_tready are both high at a rising edge.
REQ-016 The block SHALL be a two-entry skid buffer (output register plus skid register) with states EMPTY, ONE and FULL.
REQ-017 In EMPTY, an accepted beat SHALL load the output register and move to ONE; with no beat accepted the state SHALL stay EMPTY.
REQ-018 In ONE, accept plus deliver in the same cycle SHALL load the output register and stay in ONE; accept only SHALL load the skid register and move to FULL; deliver only SHALL move to EMPTY.
REQ-019 In FULL, s_axis_tready SHALL be low; a delivery SHALL copy the skid register into the output register and move to ONE; with no delivery the state SHALL stay FULL.
REQ-020 Latency from input to output SHALL be 1 cycle: a beat accepted at edge N is presented on m_axis_* after edge N.
REQ-021 The order of beats, tdata and tlast SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-022 m_axis_tvalid SHALL be high exactly in ONE and FULL.
REQ-023 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata and m_axis_tlast SHALL hold stable.
REQ-024 Once m_axis_tvalid is high, it SHALL stay high until a delivery occurs.
REQ-025 s_axis_tready SHALL be high exactly in EMPTY and ONE, except during reset and before the first edge after reset release.
REQ-026 s_axis_tready SHALL NOT depend combinationally on m_axis_tready.
REQ-027 Sustained s_axis_tvalid and m_axis_tready SHALL give a throughput of one beat per cycle.

Reset
REQ-028 While areset is high, the state SHALL be EMPTY and s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, pkt_count and last_len SHALL all be 0.
REQ-029 Reset asserted mid-packet or in FULL SHALL discard all buffered beats immediately, without waiting for a clock edge.
REQ-030 s_axis_tready SHALL first rise at the first rising edge after areset is released.

Configuration
REQ-031 The statistics feature SHALL be compiled in only when macro S_AXIS_RX_STATS_EN is defined.
REQ-032 With S_AXIS_RX_STATS_EN defined, a 16-bit current-length counter SHALL increment on each delivered beat and saturate at 0xFFFF.
REQ-033 With S_AXIS_RX_STATS_EN defined, a delivered tlast beat SHALL load last_len with the counter value plus 1 (saturating), clear the counter, and increment pkt_count, which wraps 0xFFFF to 0.
REQ-034 Without S_AXIS_RX_STATS_EN, pkt_count and last_len SHALL be constant 0 and no counter registers SHALL exist.
REQ-035 The datapath behaviour SHALL be identical with and without S_AXIS_RX_STATS_EN.

Verification
REQ-036 Single beat: after reset, one beat tdata=0xA5, tlast=1, m_axis_tready=1 -> m_axis_tvalid high for exactly 1 cycle with 0xA5, tlast=1; pkt_count=1, last_len=1.
REQ-037 Backpressure: m_axis_tready=0, send beats 0x1, 0x2, 0x3 -> 0x1 and 0x2 accepted, s_axis_tready low after 2 beats, m_axis_tdata held at 0x1; then m_axis_tready=1 -> output 0x1, 0x2, 0x3 in order.
REQ-038 Streaming: 4-beat packet 0x10..0x13 with both readies constantly high -> 4 consecutive output cycles; last_len=4, pkt_count=1.
REQ-039 Random valid and ready at 50% over 1000 beats -> output sequence identical to input, and stall stability (REQ-023, REQ-024) never violated.
REQ-040 Reset in FULL: areset pulsed mid-packet -> m_axis_tvalid=0 immediately, counters 0, and the next packet starts counting length from 1.
REQ-041 Wrap: 65536 single-beat packets with S_AXIS_RX_STATS_EN defined -> pkt_count returns to 0.
